spi_reg_bank: RTL and testbench

Register-file front end that sits directly downstream of the 8-bit SPI slave (mode 3) and consumes its received bytes. It also drives the slave's transmit byte.

- Decodes each chip-select frame as a command byte followed by data bytes.
- Implements a bank of NREGS 8-bit read/write registers with address auto-increment, exposed to the rest of the fabric.

---
 rtl/spi_reg_bank.sv | 135 +++++++++++++
 tb/tb_spi_reg_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register-file front end for an 8-bit SPI slave.
// Each chip-select frame is one command byte followed by any number of data
// bytes. Bit 7 of the command selects read (1) or write (0). The low AW bits
// of the command give the start address, which advances modulo NREGS after
// every data byte.
module spi_reg_bank #(
    parameter int          AW          = 4,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 csn,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic [8*(2**AW)-1:0] regs_out,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);

    localparam int NREGS = 2**AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t          state_r;
    logic            csn_sync1_r;
    logic            csn_sync2_r;
    logic            rx_ready_d_r;
    logic [AW-1:0]   addr_r;
    logic [7:0]      regs_r [NREGS];

    logic            csn_act_s;
    logic            rx_stb_s;
    logic [AW-1:0]   addr_nxt_s;

    assign csn_act_s  = ~csn_sync2_r;
    assign rx_stb_s   = rx_ready & ~rx_ready_d_r & csn_act_s;
    assign addr_nxt_s = addr_r + AW'(1);

    // Bring the asynchronous chip select into clk domain and delay rx_ready for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_sync1_r  <= 1'b1;
            csn_sync2_r  <= 1'b1;
            rx_ready_d_r <= 1'b0;
        end else begin
            csn_sync1_r  <= csn;
            csn_sync2_r  <= csn_sync1_r;
            rx_ready_d_r <= rx_ready;
        end
    end

    // Frame FSM: command decode, register writes, auto-increment and transmit byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            addr_r  <= '0;
            tx_data <= STATUS_BYTE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            busy    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            wr_en <= 1'b0;
            if (!csn_act_s) begin
                // Deselect wins over a byte strobe in the same cycle; that byte is dropped.
                state_r <= IDLE;
                tx_data <= STATUS_BYTE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= CMD;
                        tx_data <= STATUS_BYTE;
                        busy    <= 1'b1;
                    end
                    CMD: begin
                        if (rx_stb_s) begin
                            addr_r <= rx_data[AW-1:0];
                            if (rx_data[7]) begin
                                state_r <= RD;
                                tx_data <= regs_r[rx_data[AW-1:0]];
                            end else begin
                                state_r <= WR;
                                tx_data <= rx_data;
                            end
                        end
                    end
                    RD: begin
                        // Incoming byte is a dummy; pre-load the next register for shift-out.
                        if (rx_stb_s) begin
                            addr_r  <= addr_nxt_s;
                            tx_data <= regs_r[addr_nxt_s];
                        end
                    end
                    WR: begin
                        if (rx_stb_s) begin
                            regs_r[addr_r] <= rx_data;
                            wr_en          <= 1'b1;
                            wr_addr        <= addr_r;
                            wr_data        <= rx_data;
                            addr_r         <= addr_nxt_s;
                            tx_data        <= rx_data;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        tx_data <= STATUS_BYTE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Flatten the register array onto the fabric-facing bus
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_out[8*i +: 8] = regs_r[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames plus random frames
// compared against a frame-level model of the register bank.
module tb_spi_reg_bank;

    localparam int AW    = 4;
    localparam int NREGS = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 csn;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic [8*NREGS-1:0]   regs_out;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [7:0]           wr_data;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]    mregs [NREGS];
    logic [AW-1:0] maddr;
    bit            is_read;
    int            idx;

    always #5 clk = ~clk;

    spi_reg_bank #(.AW(AW), .STATUS_BYTE(8'hA5), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .csn      (csn),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .regs_out (regs_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mregs[i];
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    endtask

    task automatic frame_start();
        csn = 1'b0;
        idx = 0;
        repeat (4) tick();
        check_eq("busy_start", busy, 1);
        check_eq("tx_status_start", tx_data, 8'hA5);
    endtask

    task automatic frame_end();
        csn = 1'b1;
        repeat (4) tick();
        check_eq("busy_end", busy, 0);
        check_eq("tx_status_end", tx_data, 8'hA5);
        check_eq("regs_after_frame", regs_out, model_vec());
    endtask

    // One received byte: rx_ready held for 'hold' cycles, then low for two.
    task automatic send_byte(input logic [7:0] b, input int hold);
        logic [7:0]    etx;
        logic          ewr;
        logic [AW-1:0] ewa;
        ewr = 1'b0;
        ewa = '0;
        if (idx == 0) begin
            maddr   = b[AW-1:0];
            is_read = b[7];
            etx     = is_read ? mregs[maddr] : b;
        end else if (is_read) begin
            maddr = maddr + 1;
            etx   = mregs[maddr];
        end else begin
            ewr          = 1'b1;
            ewa          = maddr;
            mregs[maddr] = b;
            maddr        = maddr + 1;
            etx          = b;
        end
        idx++;
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        check_eq("tx_data", tx_data, etx);
        check_eq("wr_en", wr_en, ewr);
        if (ewr) begin
            check_eq("wr_addr", wr_addr, ewa);
            check_eq("wr_data", wr_data, b);
        end
        check_eq("regs_out", regs_out, model_vec());
        for (int k = 1; k < hold; k++) begin
            tick();
            check_eq("wr_en_hold", wr_en, 0);
            check_eq("tx_hold", tx_data, etx);
        end
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        tick();
        check_eq("wr_en_gap", wr_en, 0);
        tick();
    endtask

    initial begin
        rstn     = 1'b0;
        csn      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        idx = 0;
        repeat (3) tick();
        check_eq("rst_tx", tx_data, 8'hA5);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_regs", regs_out, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Write frame 03 11 22
        frame_start();
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 2);
        frame_end();
        check_eq("reg3", regs_out[31:24], 8'h11);
        check_eq("reg4", regs_out[39:32], 8'h22);

        // Read frame 83 00 00
        frame_start();
        send_byte(8'h83, 1);
        check_eq("rd_b0", tx_data, 8'h11);
        send_byte(8'h00, 3);
        check_eq("rd_b1", tx_data, 8'h22);
        send_byte(8'h00, 1);
        frame_end();

        // Wrap write 0F AA BB
        frame_start();
        send_byte(8'h0F, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        check_eq("wrap_addr", wr_addr, 0);
        frame_end();
        check_eq("reg15", regs_out[127:120], 8'hAA);
        check_eq("reg0", regs_out[7:0], 8'hBB);

        // Abort mid data byte: no strobe arrives before deselect
        frame_start();
        send_byte(8'h05, 1);
        rx_data = 8'h99;
        repeat (5) tick();
        frame_end();
        check_eq("abort_no_wr", wr_en, 0);
        // Next frame must decode its first byte as a command
        frame_start();
        send_byte(8'h85, 1);
        send_byte(8'h00, 1);
        frame_end();

        // Strobe arriving once the synchronised select has dropped is discarded
        frame_start();
        send_byte(8'h06, 1);
        csn = 1'b1;
        tick();
        tick();
        rx_data  = 8'hEE;
        rx_ready = 1'b1;
        tick();
        check_eq("coinc_wr_en", wr_en, 0);
        check_eq("coinc_busy", busy, 0);
        rx_ready = 1'b0;
        repeat (2) tick();
        check_eq("coinc_regs", regs_out, model_vec());

        // Random frames
        for (int f = 0; f < 40; f++) begin
            int nb;
            nb = $urandom_range(0, 6);
            frame_start();
            send_byte(8'($urandom), $urandom_range(1, 4));
            for (int j = 0; j < nb; j++) send_byte(8'($urandom), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) repeat (3) tick();
            frame_end();
        end

        // Reset mid-frame while a write pulse is on the outputs
        frame_start();
        send_byte(8'h02, 1);
        send_byte(8'h5C, 1);
        rx_data  = 8'h77;
        rx_ready = 1'b1;
        tick();
        check_eq("pre_rst_wr_en", wr_en, 1);
        rstn = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_regs", regs_out, 0);
        check_eq("mid_rst_tx", tx_data, 8'hA5);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_wr_en", wr_en, 0);
        rx_ready = 1'b0;
        csn      = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (2) tick();
        frame_start();
        send_byte(8'h80, 1);
        check_eq("post_rst_reg0", tx_data, 8'h00);
        send_byte(8'h00, 1);
        frame_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
